// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor built from one DIGIT-bit adder
// slice reused over N = WIDTH/DIGIT cycles, least-significant digit first.
// Subtraction is done as A + ~B + ~ci, so co is "no borrow" when subtracting.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits added per cycle; must divide WIDTH
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high (overrides start, aborts an operation)
//   start  begin an operation; accepted only when not busy
//   sub    0 = add, 1 = subtract (latched on accept)
//   A, B   operands (latched on accept)
//   ci     carry-in for add, borrow-in for subtract (latched on accept)
//   busy   high while digits are being added
//   done   one-cycle pulse; s/co/ovf carry the new result
//   s      result, held until the next result or reset
//   co     carry-out for add, not-borrow for subtract
//   ovf    two's-complement signed overflow
module serial_add_sub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW = DIGIT + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_d;

   logic [WIDTH-1:0] ar;
   logic [WIDTH-1:0] br;
   logic [WIDTH-1:0] acc;
   logic             c;
   logic [KW-1:0]    k;

   logic             accept_c;
   logic             last_c;
   logic [DIGIT-1:0] a_dig_c;
   logic [DIGIT-1:0] b_dig_c;
   logic [DW-1:0]    dsum_c;
   logic [WIDTH-1:0] acc_nx_c;
   logic             ovf_c;

   // Start is ignored while running; it is honoured in IDLE and DONE.
   assign accept_c = start && (state != S_RUN);
   assign last_c   = (k == KW'(N - 1));

   // Next-state logic.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_c) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // One digit slice of the adder plus the accumulator with that digit merged in.
   always_comb begin
      a_dig_c  = ar[k*DIGIT +: DIGIT];
      b_dig_c  = br[k*DIGIT +: DIGIT];
      dsum_c   = DW'(a_dig_c) + DW'(b_dig_c) + DW'(c);
      acc_nx_c = acc;
      acc_nx_c[k*DIGIT +: DIGIT] = dsum_c[DIGIT-1:0];
      // Carry into the MSB is recovered from the MSB sum bit; carry out is the slice carry.
      ovf_c    = ar[WIDTH-1] ^ br[WIDTH-1] ^ acc_nx_c[WIDTH-1] ^ dsum_c[DIGIT];
   end

   // State register, status flags and datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         co    <= 1'b0;
         ovf   <= 1'b0;
         ar    <= '0;
         br    <= '0;
         acc   <= '0;
         c     <= 1'b0;
         k     <= '0;
      end else begin
         state <= state_d;
         busy  <= (state_d == S_RUN);
         done  <= (state_d == S_DONE);
         if (accept_c) begin
            ar  <= A;
            br  <= sub ? ~B : B;
            c   <= sub ? ~ci : ci;
            acc <= '0;
            k   <= '0;
         end else if (state == S_RUN) begin
            acc <= acc_nx_c;
            c   <= dsum_c[DIGIT];
            k   <= k + KW'(1);
            if (last_c) begin
               s   <= acc_nx_c;
               co  <= dsum_c[DIGIT];
               ovf <= ovf_c;
            end
         end
      end
   end

endmodule
